// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer and its return stack.
package pc_pkg;

  // Operations presented by instruction decode; codes 5..7 behave as PC_INC.
  typedef enum logic [2:0] {
    PC_INC    = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_e;

  // Stack pointer must count 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO. The pointer counts held entries; reset only
// clears the pointer, because sp=0 already makes every stored entry invalid.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned SPW = sp_width(DEPTH);
  localparam int unsigned IW  = $clog2(DEPTH);

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_dec;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic           do_push;
  logic           do_pop;

  // Push goes to slot sp, the top of stack lives at sp-1.
  assign sp_dec   = sp_q - SPW'(1);
  assign wr_idx   = sp_q[IW-1:0];
  assign rd_idx   = sp_dec[IW-1:0];
  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign pop_data = mem[rd_idx];

  // The parent already gates these; repeating it here keeps the LIFO safe on its own.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  // Stack pointer: one entry per push, one per pop, zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + SPW'(1);
    end else if (do_pop) begin
      sp_q <= sp_dec;
    end
  end

  // Entry storage: written on push only, never cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-pc selection, pc register, sticky stack
// error flag, and a return stack for CALL/RET. pc is purely registered, so
// no input reaches it combinationally.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [2:0]    op,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] offset,
  output logic [AW-1:0] pc,
  output logic          stack_empty,
  output logic          stack_full,
  output logic          stack_err
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pop_data;
  logic          err_q;
  logic          err_set;
  logic          push;
  logic          pop;
  pc_op_e        op_e;

  assign op_e   = pc_op_e'(op);
  assign pc_inc = pc_q + AW'(1);

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Next-pc mux and stack control; a stall holds everything and ignores op.
  always_comb begin
    pc_next = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (!stall) begin
      case (op_e)
        PC_JUMP:   pc_next = target;
        PC_BRANCH: pc_next = pc_q + offset;
        PC_CALL: begin
          pc_next = target;
          if (stack_full) begin
            err_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        PC_RET: begin
          if (stack_empty) begin
            pc_next = pc_inc;
            err_set = 1'b1;
          end else begin
            pc_next = pop_data;
            pop     = 1'b1;
          end
        end
        default:   pc_next = pc_inc;
      endcase
    end
  end

  // pc register; reset overrides stall and op.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Sticky stack error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign pc        = pc_q;
  assign stack_err = err_q;

endmodule
